// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one 64-bit TX stream among NUM_SRC packet sources.
// One packet per grant, enforced inter-packet gap, timeout and length guards.
module tx_arbiter #(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned GAP     = 4,
    parameter int unsigned MAX_LEN = 1025,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_SRC-1:0]      req,
    output logic [NUM_SRC-1:0]      gnt,
    input  logic [64*NUM_SRC-1:0]   src_data,
    input  logic [NUM_SRC-1:0]      src_valid,
    input  logic [NUM_SRC-1:0]      src_eod,
    output logic [63:0]             tx_data,
    output logic                    tx_valid,
    output logic                    tx_eod,
    output logic [31:0]             pkt_count,
    output logic                    err_timeout,
    output logic                    err_len,
    output logic                    err_stray
);

    localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned CNT_W = 11;
    localparam int unsigned TMR_W = 8;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_GAP} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [NUM_SRC-1:0] gnt_q, gnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [63:0]        tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic               tx_eod_q, tx_eod_d;
    logic [31:0]        pkt_q, pkt_d;
    logic               err_timeout_q, err_timeout_d;
    logic               err_len_q, err_len_d;
    logic               err_stray_q, err_stray_d;

    logic               found;
    logic [IDX_W-1:0]   pick;
    logic [IDX_W-1:0]   cand;
    logic               word_v;
    logic               word_e;
    logic [63:0]        word_data;
    logic [CNT_W-1:0]   cnt_n;

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        sel_d         = sel_q;
        gnt_d         = gnt_q;
        cnt_d         = cnt_q;
        tmr_d         = tmr_q;
        pkt_d         = pkt_q;
        tx_data_d     = '0;
        tx_valid_d    = 1'b0;
        tx_eod_d      = 1'b0;
        err_timeout_d = 1'b0;
        err_len_d     = 1'b0;
        found         = 1'b0;
        pick          = '0;
        cand          = '0;
        cnt_n         = '0;

        // First requester at or after the pointer, wrapping.
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % int'(NUM_SRC));
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end

        word_v    = src_valid[sel_q];
        word_e    = src_eod[sel_q];
        word_data = src_data[int'(sel_q)*64 +: 64];

        // Anything valid from a source not currently holding the grant is dropped.
        err_stray_d = |(src_valid & ~gnt_q);

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    gnt_d   = NUM_SRC'(1) << pick;
                    sel_d   = pick;
                    ptr_d   = (pick == IDX_W'(NUM_SRC - 1)) ? '0 : pick + IDX_W'(1);
                    tmr_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT, S_XFER: begin
                if (word_v) begin
                    cnt_n      = (state_q == S_WAIT) ? CNT_W'(1) : cnt_q + CNT_W'(1);
                    cnt_d      = cnt_n;
                    tx_data_d  = word_data;
                    tx_valid_d = 1'b1;
                    state_d    = S_XFER;
                    if (word_e || (cnt_n == CNT_W'(MAX_LEN))) begin
                        tx_eod_d  = 1'b1;
                        err_len_d = !word_e;
                        gnt_d     = '0;
                        pkt_d     = pkt_q + 32'd1;
                        tmr_d     = '0;
                        state_d   = S_GAP;
                    end
                end else if (state_q == S_WAIT) begin
                    if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                        gnt_d         = '0;
                        err_timeout_d = 1'b1;
                        tmr_d         = '0;
                        state_d       = S_GAP;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
            end
            S_GAP: begin
                // Holds GAP+1 cycles so the TX stream sees GAP idle cycles after the eod word.
                if (tmr_q == TMR_W'(GAP)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            sel_q         <= '0;
            gnt_q         <= '0;
            cnt_q         <= '0;
            tmr_q         <= '0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            tx_eod_q      <= 1'b0;
            pkt_q         <= '0;
            err_timeout_q <= 1'b0;
            err_len_q     <= 1'b0;
            err_stray_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            sel_q         <= sel_d;
            gnt_q         <= gnt_d;
            cnt_q         <= cnt_d;
            tmr_q         <= tmr_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            tx_eod_q      <= tx_eod_d;
            pkt_q         <= pkt_d;
            err_timeout_q <= err_timeout_d;
            err_len_q     <= err_len_d;
            err_stray_q   <= err_stray_d;
        end
    end

    assign gnt         = gnt_q;
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign tx_eod      = tx_eod_q;
    assign pkt_count   = pkt_q;
    assign err_timeout = err_timeout_q;
    assign err_len     = err_len_q;
    assign err_stray   = err_stray_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Scoreboard bench for tx_arbiter: directed packets push expected TX words,
// a negedge monitor pops and compares every presented word.
module tb_tx_arbiter;

    localparam int unsigned N  = 2;
    localparam int          ML = 1025;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [N-1:0]     gnt;
    logic [64*N-1:0]  src_data;
    logic [N-1:0]     src_valid;
    logic [N-1:0]     src_eod;
    logic [63:0]      tx_data;
    logic             tx_valid;
    logic             tx_eod;
    logic [31:0]      pkt_count;
    logic             err_timeout;
    logic             err_len;
    logic             err_stray;

    tx_arbiter #(.NUM_SRC(N), .GAP(4), .MAX_LEN(ML), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt),
        .src_data(src_data), .src_valid(src_valid), .src_eod(src_eod),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_eod(tx_eod),
        .pkt_count(pkt_count), .err_timeout(err_timeout),
        .err_len(err_len), .err_stray(err_stray)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] d;
        logic        e;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   gap_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_eod = 0;
    bit   have_eod = 1'b0;
    int   n_len = 0;
    int   n_stray = 0;
    int   n_to = 0;
    int   n_eod = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: compare every TX word against the scoreboard, track gaps and pulses.
    always @(negedge clk) begin
        cyc++;
        if (err_len)     n_len++;
        if (err_stray)   n_stray++;
        if (err_timeout) n_to++;
        if (tx_eod)      n_eod++;
        if (tx_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %0h with nothing expected", tx_data);
            end else begin
                mon_e = sb.pop_front();
                chk("tx_data", tx_data, mon_e.d);
                chk("tx_eod", 64'(tx_eod), 64'(mon_e.e));
            end
            if (have_eod) begin
                gap_q.push_back(cyc - last_eod - 1);
                have_eod = 1'b0;
            end
            if (tx_eod) begin
                last_eod = cyc;
                have_eod = 1'b1;
            end
        end else begin
            chk("idle_data", tx_data, 64'd0);
        end
        if (err_len) chk("err_len_with_eod", 64'(tx_eod), 64'd1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_grant(input logic [N-1:0] exp);
        int k;
        k = 0;
        while (gnt == '0 && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (gnt == '0) begin
            checks++;
            errors++;
            $display("FAIL grant_wait: gnt stayed 0 for %0d cycles, expected %b", k, exp);
        end else begin
            chk("gnt", 64'(gnt), 64'(exp));
        end
    endtask

    // Drive one packet from source s; words st_lo..st_hi also get a stray word from the other source.
    task automatic stream(input int s, input int len, input bit with_eod,
                          input logic [63:0] base, input int st_lo, input int st_hi);
        exp_t e;
        for (int w = 1; w <= len; w++) begin
            src_valid = '0;
            src_eod   = '0;
            src_valid[s] = 1'b1;
            src_data[64*s +: 64] = base + 64'(w);
            src_eod[s] = with_eod && (w == len);
            if (w >= st_lo && w <= st_hi) begin
                src_valid[1-s] = 1'b1;
                src_data[64*(1-s) +: 64] = 64'hBAD0_0000_0000_0000 | 64'(w);
            end
            if (w <= ML) begin
                chk("gnt_hold", 64'(gnt), 64'(1 << s));
                e.d = base + 64'(w);
                e.e = (with_eod && w == len) || (w == ML);
                sb.push_back(e);
            end
            tick(1);
        end
        src_valid = '0;
        src_eod   = '0;
        src_data  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int   k;
        int   to0, len0, st0, eod0;
        logic [31:0] pc0;
        exp_t e;

        rst = 1'b1; req = '0; src_valid = '0; src_eod = '0; src_data = '0;
        tick(3);
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_tx_data", tx_data, 64'd0);
        chk("rst_tx_eod", 64'(tx_eod), 64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        chk("rst_errs", 64'({err_timeout, err_len, err_stray}), 64'd0);
        rst = 1'b0;
        tick(2);

        // Single full-length packet from source 0.
        req = 2'b01;
        wait_grant(2'b01);
        req = '0;
        stream(0, ML, 1'b1, 64'h1000_0000, 0, -1);
        tick(2);
        chk("single_pkt_count", 64'(pkt_count), 64'd1);
        chk("single_sb_empty", 64'(sb.size()), 64'd0);

        // Stuck source 1: timeout after 64 cycles of grant.
        to0 = n_to;
        req = 2'b10;
        wait_grant(2'b10);
        req = '0;
        k = 0;
        while (!err_timeout && k < 200) begin
            tick(1);
            k++;
        end
        chk("timeout_cycles", 64'(k), 64'd64);
        chk("timeout_gnt_drop", 64'(gnt), 64'd0);
        tick(1);
        chk("timeout_pulses", 64'(n_to - to0), 64'd1);

        // Contention: req=11 held, grants alternate starting at source 0.
        pc0 = pkt_count;
        gap_q.delete();
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_grant(N'(1 << (i % 2)));
            if (i == 3) req = '0;
            stream(i % 2, 4, 1'b1, 64'h2000_0000 + 64'(i * 256), 0, -1);
        end
        tick(10);
        chk("cont_pkt_count", 64'(pkt_count - pc0), 64'd4);
        chk("cont_gap_entries", 64'(gap_q.size()), 64'd4);
        for (int j = 1; j < 4 && j < gap_q.size(); j++)
            chk("cont_idle_gap", 64'(gap_q[j]), 64'd6);

        // Over-long packet: truncated at MAX_LEN, remainder flagged as stray.
        len0 = n_len; st0 = n_stray; pc0 = pkt_count;
        req = 2'b01;
        wait_grant(2'b01);
        req = '0;
        stream(0, 1100, 1'b0, 64'h3000_0000, 0, -1);
        tick(2);
        chk("long_err_len", 64'(n_len - len0), 64'd1);
        chk("long_err_stray", 64'(n_stray - st0), 64'd75);
        chk("long_pkt_count", 64'(pkt_count - pc0), 64'd1);

        // Stray source 1 while source 0 transfers.
        st0 = n_stray;
        req = 2'b01;
        wait_grant(2'b01);
        req = '0;
        stream(0, 8, 1'b1, 64'h4000_0000, 3, 5);
        tick(2);
        chk("stray_pulses", 64'(n_stray - st0), 64'd3);

        // Reset on word 10 of a packet.
        req = 2'b01;
        wait_grant(2'b01);
        req = '0;
        eod0 = n_eod;
        for (int w = 1; w <= 10; w++) begin
            src_valid = 2'b01;
            src_data[63:0] = 64'h5000_0000 + 64'(w);
            if (w < 10) begin
                e.d = 64'h5000_0000 + 64'(w);
                e.e = 1'b0;
                sb.push_back(e);
            end else begin
                rst = 1'b1;
            end
            tick(1);
        end
        chk("mrst_gnt", 64'(gnt), 64'd0);
        chk("mrst_tx_valid", 64'(tx_valid), 64'd0);
        chk("mrst_tx_data", tx_data, 64'd0);
        chk("mrst_tx_eod", 64'(tx_eod), 64'd0);
        chk("mrst_pkt_count", 64'(pkt_count), 64'd0);
        rst = 1'b0; src_valid = '0; src_data = '0;
        tick(1);
        chk("mrst_no_eod", 64'(n_eod - eod0), 64'd0);
        req = 2'b10;
        wait_grant(2'b10);
        req = '0;
        stream(1, 4, 1'b1, 64'h6000_0000, 0, -1);
        tick(8);
        chk("mrst_pkt_after", 64'(pkt_count), 64'd1);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
